// File: rtl/spiking_array_ctrl_if.sv
// Handshake bundle between the spiking-array controller and its spike source / result consumer.
// A transfer happens on a posedge where valid and ready are both high; valid never waits on ready.
interface spiking_array_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             spk_valid;
  logic             spk_ready;
  logic             feed_en;
  logic             rd_valid;
  logic             rd_ready;
  logic [IDX_W-1:0] rd_idx;

  modport master (
    input  spk_valid,
    input  rd_ready,
    output spk_ready,
    output feed_en,
    output rd_valid,
    output rd_idx
  );

  modport slave (
    output spk_valid,
    output rd_ready,
    input  spk_ready,
    input  feed_en,
    input  rd_valid,
    input  rd_idx
  );
endinterface

// File: rtl/spiking_array_ctrl.sv
// Job sequencer for an N x N spiking PE array: clear, feed spike vectors, flush the
// pipeline, then read out one column result per handshake.
module spiking_array_ctrl #(
  parameter int N         = 32,
  parameter int STEP_W    = 16,
  parameter int DRAIN_CYC = 2 * N,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] cfg_steps,
  output logic              arr_rstn,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg,
  spiking_array_ctrl_if.master bus
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [STEP_W-1:0] cfg_q, cfg_n;
  logic [DRN_W-1:0]  drain_q, drain_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic              spk_ready;
  logic              rd_valid;
  logic              spk_hs;
  logic              rd_hs;

  // An abort withdraws ready/valid so the handshake it beats is never seen by either side.
  assign spk_ready = (state_q == RUN) && !abort;
  assign rd_valid  = (state_q == READ) && !abort;
  assign spk_hs    = spk_ready && bus.spk_valid;
  assign rd_hs     = rd_valid && bus.rd_ready;

  assign bus.spk_ready = spk_ready;
  assign bus.feed_en   = spk_hs;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_idx    = idx_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    cfg_n   = cfg_q;
    drain_n = drain_q;
    idx_n   = idx_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_n = CLEAR;
          cfg_n   = cfg_steps;
        end
      end
      CLEAR: begin
        state_n = (cfg_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (spk_hs) begin
          if (step_q == cfg_q - STEP_W'(1)) begin
            state_n = DRAIN;
            step_n  = '0;
          end else begin
            step_n = step_q + STEP_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_n = READ;
          drain_n = '0;
        end else begin
          drain_n = drain_q + DRN_W'(1);
        end
      end
      READ: begin
        if (rd_hs) begin
          if (idx_q == IDX_W'(N - 1)) begin
            state_n = DONE;
            idx_n   = '0;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_n = IDLE;
      step_n  = '0;
      drain_n = '0;
      idx_n   = '0;
    end
  end

  // arr_rstn and done are registered decodes of the next state, so they line up with CLEAR/DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      step_q   <= '0;
      cfg_q    <= '0;
      drain_q  <= '0;
      idx_q    <= '0;
      arr_rstn <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      step_q   <= step_n;
      cfg_q    <= cfg_n;
      drain_q  <= drain_n;
      idx_q    <= idx_n;
      arr_rstn <= (state_n != CLEAR);
      done     <= (state_n == DONE);
    end
  end

endmodule
